weight_buffer_scheduler: RTL and testbench

Ping-pong bank scheduler for the weight buffers feeding `weight_buffer_reader`. It holds two weight-buffer banks and grants the single DDR weight loader a free bank for each layer. It then starts the reader on filled banks in load order and counts layers until the configured job completes. It sits between the DDR loader, the two weight-buffer banks, and `weight_buffer_reader`, whose `start`, `wei_shape` and `ker_shape` it drives.

---
 rtl/weight_buffer_scheduler_if.sv | 41 ++++
 rtl/weight_buffer_scheduler.sv | 178 +++++++++++++++++
 tb/tb_weight_buffer_scheduler.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_buffer_scheduler_if.sv
// weight_buffer_scheduler_if
// Handshake bundle between the job controller, the DDR weight loader, the
// weight_buffer_reader and the ping-pong bank scheduler.
//   start, n_layers              : job request from the controller
//   ld_req/ld_gnt/ld_bank        : loader bank request and grant
//   ld_done, ld_wei/ker_shape    : loader completion and the loaded layer's shapes
//   rd_start/rd_bank/wei/ker_shape: reader launch and the shapes of the bank it reads
//   rd_done                      : reader completion
//   busy, done, err              : job status
// The master modport is the environment side; the slave modport is the scheduler.
interface weight_buffer_scheduler_if #(
    parameter int B_SHAPE = 48,
    parameter int B_LAYER = 8
);
    logic               start;
    logic [B_LAYER-1:0] n_layers;
    logic               ld_req;
    logic               ld_gnt;
    logic               ld_bank;
    logic               ld_done;
    logic [B_SHAPE-1:0] ld_wei_shape;
    logic [B_SHAPE-1:0] ld_ker_shape;
    logic               rd_start;
    logic               rd_bank;
    logic [B_SHAPE-1:0] wei_shape;
    logic [B_SHAPE-1:0] ker_shape;
    logic               rd_done;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, n_layers, ld_req, ld_done, ld_wei_shape, ld_ker_shape, rd_done,
        input  ld_gnt, ld_bank, rd_start, rd_bank, wei_shape, ker_shape, busy, done, err
    );

    modport slave (
        input  start, n_layers, ld_req, ld_done, ld_wei_shape, ld_ker_shape, rd_done,
        output ld_gnt, ld_bank, rd_start, rd_bank, wei_shape, ker_shape, busy, done, err
    );
endinterface

// File: rtl/weight_buffer_scheduler.sv
// weight_buffer_scheduler
// Ping-pong scheduler for the two weight-buffer banks. Grants the single DDR
// weight loader an empty bank per layer, launches weight_buffer_reader on
// filled banks in load order, and counts layers until the job completes.
// Ports:
//   clk  : clock
//   rstn : synchronous active-low reset; aborts any job in flight
//   bus  : weight_buffer_scheduler_if slave modport (see the interface header)
// All outputs are registered.
module weight_buffer_scheduler #(
    parameter int B_SHAPE = 48,
    parameter int B_LAYER = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    weight_buffer_scheduler_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_t;

    state_t             state_r;
    bank_t              bank_st_r  [2];
    logic [B_SHAPE-1:0] bank_wei_r [2];
    logic [B_SHAPE-1:0] bank_ker_r [2];
    logic [B_LAYER-1:0] n_layers_r;
    logic [B_LAYER-1:0] ld_cnt_r;
    logic [B_LAYER-1:0] rd_cnt_r;
    logic               ld_ptr_r;
    logic               rd_ptr_r;
    logic               load_out_r;
    logic               read_out_r;

    logic               grant_s;
    logic               read_s;
    logic               ld_fin_s;
    logic               rd_fin_s;
    logic               last_s;
    logic [B_LAYER-1:0] rd_cnt_inc_s;

    // Grant / read-launch / completion decisions from registered state and sampled inputs
    always_comb begin
        grant_s      = 1'b0;
        read_s       = 1'b0;
        if (state_r == RUN) begin
            grant_s = bus.ld_req && (bank_st_r[ld_ptr_r] == EMPTY) && !load_out_r
                      && (ld_cnt_r != n_layers_r);
            read_s  = (bank_st_r[rd_ptr_r] == FULL) && !read_out_r;
        end else begin
            grant_s = 1'b0;
            read_s  = 1'b0;
        end
        // Completions only count while something is outstanding; otherwise they are spurious.
        ld_fin_s     = bus.ld_done && load_out_r;
        rd_fin_s     = bus.rd_done && read_out_r;
        rd_cnt_inc_s = rd_cnt_r + B_LAYER'(1);
        last_s       = rd_fin_s && (rd_cnt_inc_s == n_layers_r);
    end

    // Job FSM, bank state machines, counters and all registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r       <= IDLE;
            for (int i = 0; i < 2; i++) begin
                bank_st_r[i]  <= EMPTY;
                bank_wei_r[i] <= {B_SHAPE{1'b0}};
                bank_ker_r[i] <= {B_SHAPE{1'b0}};
            end
            n_layers_r    <= {B_LAYER{1'b0}};
            ld_cnt_r      <= {B_LAYER{1'b0}};
            rd_cnt_r      <= {B_LAYER{1'b0}};
            ld_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            load_out_r    <= 1'b0;
            read_out_r    <= 1'b0;
            bus.ld_gnt    <= 1'b0;
            bus.ld_bank   <= 1'b0;
            bus.rd_start  <= 1'b0;
            bus.rd_bank   <= 1'b0;
            bus.wei_shape <= {B_SHAPE{1'b0}};
            bus.ker_shape <= {B_SHAPE{1'b0}};
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.ld_gnt   <= 1'b0;
            bus.rd_start <= 1'b0;
            bus.done     <= 1'b0;

            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.n_layers != {B_LAYER{1'b0}}) begin
                            state_r    <= RUN;
                            bus.busy   <= 1'b1;
                            n_layers_r <= bus.n_layers;
                            ld_cnt_r   <= {B_LAYER{1'b0}};
                            rd_cnt_r   <= {B_LAYER{1'b0}};
                            ld_ptr_r   <= 1'b0;
                            rd_ptr_r   <= 1'b0;
                        end else begin
                            // Empty job: acknowledge immediately without leaving IDLE.
                            bus.done <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (bus.start) begin
                        bus.err <= 1'b1;
                    end

                    if (grant_s) begin
                        bus.ld_gnt            <= 1'b1;
                        bus.ld_bank           <= ld_ptr_r;
                        bank_st_r[ld_ptr_r]   <= LOADING;
                        load_out_r            <= 1'b1;
                        ld_cnt_r              <= ld_cnt_r + B_LAYER'(1);
                        ld_ptr_r              <= ~ld_ptr_r;
                    end

                    // ld_bank still names the bank being loaded until the next grant,
                    // and a grant cannot coincide with a valid ld_done.
                    if (ld_fin_s) begin
                        bank_st_r[bus.ld_bank]  <= FULL;
                        bank_wei_r[bus.ld_bank] <= bus.ld_wei_shape;
                        bank_ker_r[bus.ld_bank] <= bus.ld_ker_shape;
                        load_out_r              <= 1'b0;
                    end

                    if (read_s) begin
                        bus.rd_start        <= 1'b1;
                        bus.rd_bank         <= rd_ptr_r;
                        bus.wei_shape       <= bank_wei_r[rd_ptr_r];
                        bus.ker_shape       <= bank_ker_r[rd_ptr_r];
                        bank_st_r[rd_ptr_r] <= READING;
                        read_out_r          <= 1'b1;
                    end

                    if (rd_fin_s) begin
                        bank_st_r[bus.rd_bank] <= EMPTY;
                        rd_ptr_r               <= ~rd_ptr_r;
                        rd_cnt_r               <= rd_cnt_inc_s;
                        read_out_r             <= 1'b0;
                        if (last_s) begin
                            state_r  <= IDLE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_r  <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase

            // Completions with nothing outstanding are protocol errors and are otherwise ignored.
            if (bus.ld_done && !load_out_r) begin
                bus.err <= 1'b1;
            end
            if (bus.rd_done && !read_out_r) begin
                bus.err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_weight_buffer_scheduler.sv
// tb_weight_buffer_scheduler
// Self-checking bench for weight_buffer_scheduler: hand-written cycle-exact
// sequences for the timing corner cases, a table of whole jobs with expected
// event counts, and randomized jobs checked by a transaction-level model.
module tb_weight_buffer_scheduler;

    logic clk = 1'b0;
    logic rstn;

    weight_buffer_scheduler_if #(.B_SHAPE(48), .B_LAYER(8)) bus ();

    weight_buffer_scheduler #(.B_SHAPE(48), .B_LAYER(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction-level model state, maintained by the monitor
    int m_gnts = 0;
    int m_ldd  = 0;
    int m_rds  = 0;
    int m_rdd  = 0;
    int m_done = 0;
    int m_ovl  = 0;

    logic [47:0] exp_w [$];
    logic [47:0] exp_k [$];
    logic        stop_flag = 1'b0;

    typedef struct {
        int n;
        int ldl;
        int rdl;
        int exp_gnt;
        int exp_rds;
        int exp_done;
        int exp_ovl;   // 0 = no load overlaps a read, 1 = some overlap, 2 = don't care
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: model of the scheduling rules at transaction level
    always @(negedge clk) begin
        if (!rstn) begin
            m_gnts = 0; m_ldd = 0; m_rds = 0; m_rdd = 0; m_done = 0; m_ovl = 0;
        end else begin
            if (bus.start && !bus.busy) begin
                m_gnts = 0; m_ldd = 0; m_rds = 0; m_rdd = 0; m_done = 0; m_ovl = 0;
            end
            if (bus.rd_start) begin
                check("rd_bank_order", 64'(bus.rd_bank), 64'(m_rds % 2));
                check("rd_after_load", 64'(m_rds < m_ldd), 64'd1);
                m_rds++;
            end
            if (bus.ld_gnt) begin
                check("gnt_bank_order", 64'(bus.ld_bank), 64'(m_gnts % 2));
                check("gnt_occupancy", 64'((m_gnts - m_rdd) < 2), 64'd1);
                if (m_rds > m_rdd) m_ovl++;
                m_gnts++;
            end
            if (bus.ld_done && m_ldd < m_gnts) m_ldd++;
            if (bus.rd_done && m_rdd < m_rds) m_rdd++;
            if (bus.done) begin
                m_done++;
                check("done_busy_low", 64'(bus.busy), 64'd0);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_ld_gnt"},    64'(bus.ld_gnt),    64'd0);
        check({tag, "_ld_bank"},   64'(bus.ld_bank),   64'd0);
        check({tag, "_rd_start"},  64'(bus.rd_start),  64'd0);
        check({tag, "_rd_bank"},   64'(bus.rd_bank),   64'd0);
        check({tag, "_wei_shape"}, 64'(bus.wei_shape), 64'd0);
        check({tag, "_ker_shape"}, 64'(bus.ker_shape), 64'd0);
        check({tag, "_busy"},      64'(bus.busy),      64'd0);
        check({tag, "_done"},      64'(bus.done),      64'd0);
        check({tag, "_err"},       64'(bus.err),       64'd0);
    endtask

    task automatic clear_inputs();
        bus.start = 1'b0; bus.n_layers = 8'd0; bus.ld_req = 1'b0; bus.ld_done = 1'b0;
        bus.ld_wei_shape = 48'd0; bus.ld_ker_shape = 48'd0; bus.rd_done = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        tick();
        tick();
        check_reset_vals("rst");
        rstn = 1'b1;
        tick();
    endtask

    // Wait until ld_gnt (sel 0), rd_start (sel 1) or done (sel 2) is visible
    task automatic wait_out(input int sel, input int budget, input string name);
        int cyc = 0;
        while (!((sel == 0) ? bus.ld_gnt : (sel == 1) ? bus.rd_start : bus.done) && cyc < budget) begin
            tick();
            cyc++;
        end
        if (cyc >= budget) begin
            total++;
            bad++;
            $display("FAIL %s: timeout after %0d cycles", name, cyc);
        end
    endtask

    task automatic pulse_ld_done(input logic [47:0] w, input logic [47:0] k);
        bus.ld_wei_shape = w;
        bus.ld_ker_shape = k;
        bus.ld_done      = 1'b1;
        tick();
        bus.ld_done      = 1'b0;
    endtask

    task automatic loader(input int n, input int ldl);
        logic [63:0] r;
        for (int i = 0; i < n && !stop_flag; i++) begin
            bus.ld_req = 1'b1;
            while (!bus.ld_gnt && !stop_flag) tick();
            if (stop_flag) break;
            bus.ld_req = 1'b0;
            for (int j = 0; j < ldl && !stop_flag; j++) tick();
            if (stop_flag) break;
            r = {$urandom(), $urandom()};
            bus.ld_wei_shape = r[47:0];
            r = {$urandom(), $urandom()};
            bus.ld_ker_shape = r[47:0];
            exp_w.push_back(bus.ld_wei_shape);
            exp_k.push_back(bus.ld_ker_shape);
            bus.ld_done = 1'b1;
            tick();
            bus.ld_done = 1'b0;
        end
        bus.ld_req  = 1'b0;
        bus.ld_done = 1'b0;
    endtask

    task automatic reader(input int n, input int rdl);
        for (int i = 0; i < n && !stop_flag; i++) begin
            while (!bus.rd_start && !stop_flag) tick();
            if (stop_flag) break;
            if (exp_w.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: rd_start with no loaded layer pending");
            end else begin
                check("rd_wei_shape", 64'(bus.wei_shape), 64'(exp_w.pop_front()));
                check("rd_ker_shape", 64'(bus.ker_shape), 64'(exp_k.pop_front()));
            end
            for (int j = 0; j < rdl && !stop_flag; j++) tick();
            if (stop_flag) break;
            bus.rd_done = 1'b1;
            tick();
            bus.rd_done = 1'b0;
        end
        bus.rd_done = 1'b0;
    endtask

    // Run one job with a responsive loader/reader; abort_rd>0 resets the DUT during that read
    task automatic job(input vec_t v, input int abort_rd, input string tag);
        int cyc = 0;
        stop_flag = 1'b0;
        exp_w.delete();
        exp_k.delete();
        bus.n_layers = 8'(v.n);
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        fork
            loader(v.n, v.ldl);
            reader(v.n, v.rdl);
            begin
                while (!stop_flag) begin
                    if (bus.done) begin
                        stop_flag = 1'b1;
                    end else if (abort_rd > 0 && m_rds >= abort_rd) begin
                        tick();
                        tick();
                        rstn      = 1'b0;
                        stop_flag = 1'b1;
                        tick();
                        check_reset_vals({tag, "_abort"});
                        tick();
                        rstn      = 1'b1;
                    end else if (cyc >= 5000) begin
                        total++;
                        bad++;
                        $display("FAIL %s_timeout: no done after %0d cycles", tag, cyc);
                        stop_flag = 1'b1;
                    end else begin
                        tick();
                        cyc++;
                    end
                end
            end
        join
        tick();
        if (abort_rd == 0) begin
            check({tag, "_gnt_cnt"},  64'(m_gnts), 64'(v.exp_gnt));
            check({tag, "_rd_cnt"},   64'(m_rds),  64'(v.exp_rds));
            check({tag, "_done_cnt"}, 64'(m_done), 64'(v.exp_done));
            check({tag, "_err"},      64'(bus.err),  64'd0);
            check({tag, "_busy"},     64'(bus.busy), 64'd0);
            if (v.exp_ovl != 2) check({tag, "_overlap"}, 64'(m_ovl > 0), 64'(v.exp_ovl));
        end
    endtask

    initial begin
        vec_t tbl [4];
        vec_t rv;
        int   gcnt;

        tbl[0] = '{n: 1, ldl: 2, rdl: 3,  exp_gnt: 1, exp_rds: 1, exp_done: 1, exp_ovl: 0};
        tbl[1] = '{n: 4, ldl: 0, rdl: 20, exp_gnt: 4, exp_rds: 4, exp_done: 1, exp_ovl: 1};
        tbl[2] = '{n: 0, ldl: 1, rdl: 1,  exp_gnt: 0, exp_rds: 0, exp_done: 1, exp_ovl: 0};
        tbl[3] = '{n: 3, ldl: 5, rdl: 0,  exp_gnt: 3, exp_rds: 3, exp_done: 1, exp_ovl: 2};

        clear_inputs();
        do_reset();

        // Single layer, cycle-exact
        bus.n_layers = 8'd1; bus.start = 1'b1; bus.ld_req = 1'b1;
        tick();
        bus.start = 1'b0;
        check("one_busy", 64'(bus.busy), 64'd1);
        check("one_gnt_early", 64'(bus.ld_gnt), 64'd0);
        tick();
        check("one_gnt", 64'(bus.ld_gnt), 64'd1);
        check("one_ld_bank", 64'(bus.ld_bank), 64'd0);
        bus.ld_req = 1'b0;
        pulse_ld_done(48'h0040_0003_0003, 48'h0003_0003_0040);
        check("one_rd_early", 64'(bus.rd_start), 64'd0);
        tick();
        check("one_rd_start", 64'(bus.rd_start), 64'd1);
        check("one_rd_bank", 64'(bus.rd_bank), 64'd0);
        check("one_wei", 64'(bus.wei_shape), 64'h0040_0003_0003);
        check("one_ker", 64'(bus.ker_shape), 64'h0003_0003_0040);
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        check("one_done", 64'(bus.done), 64'd1);
        check("one_busy_low", 64'(bus.busy), 64'd0);
        tick();
        check("one_done_pulse", 64'(bus.done), 64'd0);
        check("one_wei_held", 64'(bus.wei_shape), 64'h0040_0003_0003);

        // Spurious rd_done in IDLE, then empty job
        do_reset();
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        check("spur_err", 64'(bus.err), 64'd1);
        bus.n_layers = 8'd0; bus.start = 1'b1; bus.ld_req = 1'b1;
        tick();
        bus.start = 1'b0;
        check("zero_done", 64'(bus.done), 64'd1);
        check("zero_busy", 64'(bus.busy), 64'd0);
        tick();
        check("zero_done_pulse", 64'(bus.done), 64'd0);
        check("zero_err_sticky", 64'(bus.err), 64'd1);
        check("zero_no_gnt", 64'(m_gnts), 64'd0);
        check("zero_gnt_low", 64'(bus.ld_gnt), 64'd0);

        // Both banks full with a slow reader
        do_reset();
        bus.n_layers = 8'd3; bus.start = 1'b1; bus.ld_req = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_out(0, 20, "bf_gnt0");
        check("bf_bank0", 64'(bus.ld_bank), 64'd0);
        pulse_ld_done(48'h0010_0002_0002, 48'h0002_0002_0010);
        wait_out(0, 20, "bf_gnt1");
        check("bf_bank1", 64'(bus.ld_bank), 64'd1);
        pulse_ld_done(48'h0020_0004_0004, 48'h0004_0004_0020);
        gcnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.ld_gnt) gcnt++;
        end
        check("bf_no_gnt", 64'(gcnt), 64'd0);
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        check("bf_gnt_t1", 64'(bus.ld_gnt), 64'd0);
        tick();
        check("bf_gnt_t2", 64'(bus.ld_gnt), 64'd1);
        check("bf_gnt_bank", 64'(bus.ld_bank), 64'd0);
        check("bf_rd_t2", 64'(bus.rd_start), 64'd1);
        check("bf_rd_bank", 64'(bus.rd_bank), 64'd1);
        check("bf_rd_wei", 64'(bus.wei_shape), 64'h0020_0004_0004);

        // ld_done and rd_done in the same cycle, then a stray start while running
        do_reset();
        bus.n_layers = 8'd3; bus.start = 1'b1; bus.ld_req = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_out(0, 20, "sc_gnt0");
        pulse_ld_done(48'h0011_0001_0001, 48'h0001_0001_0011);
        wait_out(0, 20, "sc_gnt1");
        check("sc_rd0", 64'(bus.rd_start), 64'd1);
        check("sc_rd0_bank", 64'(bus.rd_bank), 64'd0);
        bus.ld_wei_shape = 48'h0022_0005_0005;
        bus.ld_ker_shape = 48'h0005_0005_0022;
        bus.ld_done = 1'b1;
        bus.rd_done = 1'b1;
        tick();
        bus.ld_done = 1'b0;
        bus.rd_done = 1'b0;
        check("sc_rd_gap", 64'(bus.rd_start), 64'd0);
        tick();
        check("sc_rd1", 64'(bus.rd_start), 64'd1);
        check("sc_rd1_bank", 64'(bus.rd_bank), 64'd1);
        check("sc_rd1_wei", 64'(bus.wei_shape), 64'h0022_0005_0005);
        check("sc_rd1_ker", 64'(bus.ker_shape), 64'h0005_0005_0022);
        check("sc_gnt2", 64'(bus.ld_gnt), 64'd1);
        check("sc_gnt2_bank", 64'(bus.ld_bank), 64'd0);
        check("sc_err", 64'(bus.err), 64'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("run_start_err", 64'(bus.err), 64'd1);
        check("run_start_busy", 64'(bus.busy), 64'd1);

        // Table of whole jobs
        do_reset();
        for (int i = 0; i < 4; i++) begin
            job(tbl[i], 0, $sformatf("tbl%0d", i));
        end

        // Randomized jobs
        for (int i = 0; i < 6; i++) begin
            rv.n       = int'($urandom_range(1, 6));
            rv.ldl     = int'($urandom_range(0, 4));
            rv.rdl     = int'($urandom_range(0, 8));
            rv.exp_gnt = rv.n;
            rv.exp_rds = rv.n;
            rv.exp_done = 1;
            rv.exp_ovl = 2;
            job(rv, 0, $sformatf("rnd%0d", i));
        end

        // Reset during the third read of a four-layer job, then a fresh job
        rv = '{n: 4, ldl: 2, rdl: 10, exp_gnt: 0, exp_rds: 0, exp_done: 0, exp_ovl: 2};
        job(rv, 3, "abort");
        rv = '{n: 2, ldl: 1, rdl: 3, exp_gnt: 2, exp_rds: 2, exp_done: 1, exp_ovl: 2};
        job(rv, 0, "fresh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
